// File: rtl/ring_checker.sv
// ring_checker: receive-side monitor for a rotating one-hot (ring) code.
// Decodes each valid sample to a binary index, checks that successive
// samples follow the expected rotation, tracks lock with a SEARCH/TRACK/LOCKED
// FSM, and keeps a saturating count of sequence errors.
//
// Ports:
//   clk       - clock, rising edge
//   n_rst     - asynchronous active-low reset
//   in_valid  - sample in_ring this cycle
//   in_ring   - ring code under test (WIDTH_REG bits)
//   clr_err   - synchronous clear of err_cnt (an error in the same cycle counts as 1)
//   idx_out   - index of the set bit in the last valid one-hot sample
//   idx_valid - last sample was valid and exactly one-hot
//   locked    - FSM is in LOCKED
//   err_pulse - one-cycle flag for an errored sample
//   err_cnt   - saturating error count (ERR_W bits)
module ring_checker #(
  parameter int unsigned WIDTH_REG = 32,
  parameter int unsigned LOCK_CNT  = 4,
  parameter bit          ROT_LEFT  = 1'b1,
  parameter int unsigned ERR_W     = 8
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         in_valid,
  input  logic [WIDTH_REG-1:0]         in_ring,
  input  logic                         clr_err,
  output logic [$clog2(WIDTH_REG)-1:0] idx_out,
  output logic                         idx_valid,
  output logic                         locked,
  output logic                         err_pulse,
  output logic [ERR_W-1:0]             err_cnt
);

  localparam int unsigned IW = $clog2(WIDTH_REG);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t         r_state, w_state_nxt;
  logic [IW-1:0]  r_anchor, w_anchor_nxt;
  logic [7:0]     r_good, w_good_nxt;
  logic [IW-1:0]  w_idx;
  logic [IW-1:0]  w_expect;
  logic           w_onehot;
  logic           w_err;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign w_onehot = (in_ring != '0) &&
                    ((in_ring & (in_ring - WIDTH_REG'(1))) == '0);

  // OR-reduction decode: correct only for one-hot input, which is the only
  // case whose result is ever stored.
  always_comb begin
    w_idx = '0;
    for (int unsigned i = 0; i < WIDTH_REG; i++) begin
      if (in_ring[i]) w_idx = w_idx | IW'(i);
    end
  end

  always_comb begin
    w_expect = '0;
    if (ROT_LEFT) begin
      w_expect = (r_anchor == IW'(WIDTH_REG - 1)) ? '0 : r_anchor + IW'(1);
    end else begin
      w_expect = (r_anchor == '0) ? IW'(WIDTH_REG - 1) : r_anchor - IW'(1);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_anchor_nxt = r_anchor;
    w_good_nxt   = r_good;
    w_err        = 1'b0;
    if (in_valid) begin
      case (r_state)
        SEARCH: begin
          if (w_onehot) begin
            w_state_nxt  = TRACK;
            w_anchor_nxt = w_idx;
            w_good_nxt   = '0;
          end
        end
        TRACK, LOCKED: begin
          if (!w_onehot) begin
            w_err       = 1'b1;
            w_state_nxt = SEARCH;
            w_good_nxt  = '0;
          end else if (w_idx != w_expect) begin
            w_err        = 1'b1;
            w_state_nxt  = TRACK;
            w_anchor_nxt = w_idx;
            w_good_nxt   = '0;
          end else begin
            w_anchor_nxt = w_idx;
            if (r_state == TRACK) begin
              w_good_nxt = r_good + 8'd1;
              if (w_good_nxt == 8'(LOCK_CNT)) w_state_nxt = LOCKED;
            end
          end
        end
        default: w_state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= SEARCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_anchor  <= '0;
      r_good    <= '0;
      idx_out   <= '0;
      idx_valid <= 1'b0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      r_anchor  <= w_anchor_nxt;
      r_good    <= w_good_nxt;
      idx_valid <= in_valid && w_onehot;
      locked    <= (w_state_nxt == LOCKED);
      err_pulse <= w_err;
      if (in_valid && w_onehot) idx_out <= w_idx;
      // Clear takes priority, but an error in the same cycle is still counted.
      if (clr_err) begin
        err_cnt <= w_err ? ERR_W'(1) : '0;
      end else if (w_err && (err_cnt != '1)) begin
        err_cnt <= err_cnt + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ring_checker.sv
module tb_ring_checker;

  localparam int LOCK = 4;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_ring = '0;
  logic        clr_err = 1'b0;
  logic [4:0]  idx_out;
  logic        idx_valid, locked, err_pulse;
  logic [7:0]  err_cnt;

  logic        in_valid_r = 1'b0;
  logic [31:0] in_ring_r = '0;
  logic [4:0]  idx_out_r;
  logic        idx_valid_r, locked_r, err_pulse_r;
  logic [7:0]  err_cnt_r;

  int n_cmp = 0;
  int n_bad = 0;

  // Packed observation: {idx_out, idx_valid, locked, err_pulse, err_cnt}
  logic [15:0] obs;
  logic [15:0] exp_v;
  logic [15:0] sb[$];

  // Reference model state (left rotation, width 32)
  int          m_state;   // 0 search, 1 track, 2 locked
  int          m_anchor;
  int          m_good;
  int          m_cnt;
  logic [4:0]  m_idx;

  assign obs = {idx_out, idx_valid, locked, err_pulse, err_cnt};

  always #5 clk = ~clk;

  ring_checker #(.WIDTH_REG(32), .LOCK_CNT(LOCK), .ROT_LEFT(1'b1), .ERR_W(8)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ring(in_ring),
    .clr_err(clr_err), .idx_out(idx_out), .idx_valid(idx_valid),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  ring_checker #(.WIDTH_REG(32), .LOCK_CNT(LOCK), .ROT_LEFT(1'b0), .ERR_W(8)) dut_r (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid_r), .in_ring(in_ring_r),
    .clr_err(clr_err), .idx_out(idx_out_r), .idx_valid(idx_valid_r),
    .locked(locked_r), .err_pulse(err_pulse_r), .err_cnt(err_cnt_r)
  );

  task automatic model_reset();
    m_state = 0; m_anchor = 0; m_good = 0; m_cnt = 0; m_idx = '0;
    sb.delete();
  endtask

  // Drive one sample, push the model's expected outputs, advance one edge.
  task automatic step(input logic v, input logic [31:0] r, input logic c);
    int  k;
    bit  oh;
    bit  err;
    int  nxt;
    in_valid = v; in_ring = r; clr_err = c;
    oh = ($countones(r) == 1);
    k = 0;
    for (int i = 0; i < 32; i++) if (r[i]) k = i;
    err = 1'b0;
    if (v) begin
      if (oh) m_idx = 5'(k);
      if (m_state == 0) begin
        if (oh) begin m_anchor = k; m_good = 0; m_state = 1; end
      end else begin
        nxt = (m_anchor + 1) % 32;
        if (!oh) begin
          err = 1'b1; m_state = 0; m_good = 0;
        end else if (k != nxt) begin
          err = 1'b1; m_anchor = k; m_good = 0; m_state = 1;
        end else begin
          m_anchor = k;
          if (m_state == 1) begin
            m_good++;
            if (m_good == LOCK) m_state = 2;
          end
        end
      end
    end
    if (c) m_cnt = err ? 1 : 0;
    else if (err && m_cnt < 255) m_cnt++;
    sb.push_back({m_idx, v && oh, m_state == 2, err, 8'(m_cnt)});
    @(posedge clk); #1;
    in_valid = 1'b0; clr_err = 1'b0;
  endtask

  task automatic apply_reset();
    n_rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    n_rst = 1'b1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 16'h0) begin
      n_bad++; $display("FAIL reset_async: got %h exp %h", obs, 16'h0);
    end
    apply_reset();
    step(1'b0, 32'h0, 1'b0);
    exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL reset_idle: got %h exp %h", obs, exp_v); end
    n_cmp++;
    if (obs !== 16'h0) begin n_bad++; $display("FAIL reset_zero: got %h exp %h", obs, 16'h0); end
  endtask

  task automatic test_lock();
    logic [31:0] seq [5] = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h10};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, seq[i], 1'b0);
      exp_v = sb.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL lock_step%0d: got %h exp %h", i, obs, exp_v); end
      n_cmp++;
      if (idx_out !== 5'(i) || idx_valid !== 1'b1) begin
        n_bad++; $display("FAIL lock_idx%0d: got %0d/%b exp %0d/1", i, idx_out, idx_valid, i);
      end
    end
    n_cmp++;
    if (locked !== 1'b1 || err_cnt !== 8'd0) begin
      n_bad++; $display("FAIL lock_final: got locked=%b cnt=%0d exp locked=1 cnt=0", locked, err_cnt);
    end
  endtask

  task automatic test_mismatch();
    step(1'b1, 32'h40, 1'b0);
    exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL mis_step: got %h exp %h", obs, exp_v); end
    n_cmp++;
    if (err_pulse !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b0 || idx_out !== 5'd6) begin
      n_bad++;
      $display("FAIL mis_err: got p=%b c=%0d l=%b i=%0d exp p=1 c=1 l=0 i=6",
               err_pulse, err_cnt, locked, idx_out);
    end
    for (int b = 7; b <= 11; b++) begin
      step(1'b1, 32'd1 << b, 1'b0);
      exp_v = sb.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL relock_bit%0d: got %h exp %h", b, obs, exp_v); end
      if (b == 10) begin
        n_cmp++;
        if (locked !== 1'b1) begin n_bad++; $display("FAIL relock_at4: got %b exp 1", locked); end
      end
    end
  endtask

  task automatic test_invalid();
    step(1'b1, 32'h3, 1'b0);
    exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL inv_multi: got %h exp %h", obs, exp_v); end
    n_cmp++;
    if (idx_valid !== 1'b0 || idx_out !== 5'd11 || err_pulse !== 1'b1 || err_cnt !== 8'd2 || locked !== 1'b0) begin
      n_bad++;
      $display("FAIL inv_fields: got v=%b i=%0d p=%b c=%0d l=%b exp v=0 i=11 p=1 c=2 l=0",
               idx_valid, idx_out, err_pulse, err_cnt, locked);
    end
    step(1'b1, 32'h0, 1'b0);
    exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL inv_zero: got %h exp %h", obs, exp_v); end
    n_cmp++;
    if (err_pulse !== 1'b0 || err_cnt !== 8'd2) begin
      n_bad++; $display("FAIL inv_zero_noerr: got p=%b c=%0d exp p=0 c=2", err_pulse, err_cnt);
    end
    step(1'b1, 32'h1, 1'b0);
    exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL inv_restart: got %h exp %h", obs, exp_v); end
  endtask

  task automatic test_wrap_left();
    int bits [7] = '{27, 28, 29, 30, 31, 0, 1};
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 32'd1 << bits[i], 1'b0);
      exp_v = sb.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL wrapl_bit%0d: got %h exp %h", bits[i], obs, exp_v); end
      step(1'b0, 32'hFFFF_FFFF, 1'b0);
      exp_v = sb.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL wrapl_gap%0d: got %h exp %h", i, obs, exp_v); end
    end
    n_cmp++;
    if (locked !== 1'b1 || err_cnt !== 8'd0 || idx_out !== 5'd1) begin
      n_bad++; $display("FAIL wrapl_final: got l=%b c=%0d i=%0d exp l=1 c=0 i=1", locked, err_cnt, idx_out);
    end
  endtask

  task automatic test_wrap_right();
    int bits [7] = '{4, 3, 2, 1, 0, 31, 30};
    for (int i = 0; i < 7; i++) begin
      in_valid_r = 1'b1; in_ring_r = 32'd1 << bits[i];
      @(posedge clk); #1;
      n_cmp++;
      if (err_pulse_r !== 1'b0 || idx_out_r !== 5'(bits[i]) || idx_valid_r !== 1'b1) begin
        n_bad++;
        $display("FAIL wrapr_bit%0d: got p=%b i=%0d v=%b exp p=0 i=%0d v=1",
                 bits[i], err_pulse_r, idx_out_r, idx_valid_r, bits[i]);
      end
      in_valid_r = 1'b0; in_ring_r = 32'h3;
      @(posedge clk); #1;
      n_cmp++;
      if (idx_valid_r !== 1'b0 || err_pulse_r !== 1'b0) begin
        n_bad++; $display("FAIL wrapr_gap%0d: got v=%b p=%b exp v=0 p=0", i, idx_valid_r, err_pulse_r);
      end
    end
    n_cmp++;
    if (locked_r !== 1'b1 || err_cnt_r !== 8'd0) begin
      n_bad++; $display("FAIL wrapr_final: got l=%b c=%0d exp l=1 c=0", locked_r, err_cnt_r);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    step(1'b1, 32'h1, 1'b0);
    exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL sat_start: got %h exp %h", obs, exp_v); end
    for (int i = 0; i < 300; i++) begin
      step(1'b1, (i % 2 == 0) ? 32'h20 : 32'h1, 1'b0);
      exp_v = sb.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL sat_err%0d: got %h exp %h", i, obs, exp_v); end
    end
    n_cmp++;
    if (err_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_max: got %0d exp 255", err_cnt); end
    step(1'b0, 32'h0, 1'b1);
    exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL clr_alone: got %h exp %h", obs, exp_v); end
    n_cmp++;
    if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL clr_zero: got %0d exp 0", err_cnt); end
    step(1'b1, 32'h20, 1'b1);
    exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL clr_with_err: got %h exp %h", obs, exp_v); end
    n_cmp++;
    if (err_cnt !== 8'd1 || err_pulse !== 1'b1) begin
      n_bad++; $display("FAIL clr_one: got c=%0d p=%b exp c=1 p=1", err_cnt, err_pulse);
    end
  endtask

  task automatic test_reset_midlock();
    for (int b = 6; b <= 9; b++) begin
      step(1'b1, 32'd1 << b, 1'b0);
      exp_v = sb.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL mid_bit%0d: got %h exp %h", b, obs, exp_v); end
    end
    n_cmp++;
    if (locked !== 1'b1) begin n_bad++; $display("FAIL mid_locked: got %b exp 1", locked); end
    n_rst = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (obs !== 16'h0) begin n_bad++; $display("FAIL mid_async: got %h exp %h", obs, 16'h0); end
    n_rst = 1'b1;
    step(1'b1, 32'd1 << 10, 1'b0);
    exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL mid_restart: got %h exp %h", obs, exp_v); end
    n_cmp++;
    if (err_pulse !== 1'b0 || locked !== 1'b0 || idx_out !== 5'd10) begin
      n_bad++; $display("FAIL mid_search: got p=%b l=%b i=%0d exp p=0 l=0 i=10", err_pulse, locked, idx_out);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_mismatch();
    test_invalid();
    test_wrap_left();
    test_wrap_right();
    test_saturation();
    test_reset_midlock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
